// File: rtl/fb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_pkg                                                                   |
// | Shared types, constants and helpers for the frame-buffer stream reader.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package fb_pkg;

  typedef enum logic [1:0] {
    FILL0  = 2'd0,
    FILL1  = 2'd1,
    FILL2  = 2'd2,
    STREAM = 2'd3
  } fb_state_t;

  localparam int GRAY_W       = 4;
  localparam int PIX_PER_BYTE = 2;

  function automatic logic [31:0] byte_addr(input logic [31:0] ptr);
    return ptr / 32'(PIX_PER_BYTE);
  endfunction

  // Replace one nibble of a packed pixel byte; hi selects the odd pixel.
  function automatic logic [7:0] set_nibble(input logic [7:0] b, input logic hi,
                                            input logic [GRAY_W-1:0] v);
    logic [7:0] r;
    r = b;
    if (hi) r[7:4] = v;
    else    r[3:0] = v;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_stream_reader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_stream_reader_if                                                      |
// | Pixel stream, GPU write and RAM port bundle of the frame-buffer reader.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface fb_stream_reader_if
  import fb_pkg::*;
#(
  parameter int PTR_W  = 15,
  parameter int MEM_AW = 14
);
  logic              next_pixel_in;
  logic              frame_reset_in;
  logic [GRAY_W-1:0] pixel_out;
  logic              wr_valid;
  logic              wr_ready;
  logic [PTR_W-1:0]  wr_addr;
  logic [GRAY_W-1:0] wr_data;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [1:0]        mem_wmask;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  next_pixel_in, frame_reset_in, wr_valid, wr_addr, wr_data, mem_rdata,
    output pixel_out, wr_ready, mem_addr, mem_re, mem_we, mem_wmask, mem_wdata
  );

  modport master (
    output next_pixel_in, frame_reset_in, wr_valid, wr_addr, wr_data, mem_rdata,
    input  pixel_out, wr_ready, mem_addr, mem_re, mem_we, mem_wmask, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/fb_edge_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_edge_detect                                                           |
// | Rising-edge detector against a registered copy of the input.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fb_edge_detect (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic sig_in,
  output logic      rise
);
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= sig_in;
  end

  assign rise = sig_in & ~r_prev;
endmodule
`default_nettype wire

// File: rtl/fb_stream_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_stream_reader                                                         |
// | Streams 4-bit pixels out of a packed byte RAM and arbitrates GPU writes. |
// | Optional macro FB_UNDERFLOW_FLAG_EN adds the sticky underflow_out port.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fb_stream_reader
  import fb_pkg::*;
#(
  parameter int FB_PIXELS = 30000,
  parameter int PTR_W     = $clog2(FB_PIXELS),
  parameter int MEM_AW    = PTR_W - 1
) (
  input  wire logic clk,
  input  wire logic rst_n,
`ifdef FB_UNDERFLOW_FLAG_EN
  output logic      underflow_out,
`endif
  fb_stream_reader_if.slave bus
);
  localparam int NBYTES = FB_PIXELS / PIX_PER_BYTE;

  fb_state_t         r_state;
  logic [PTR_W-1:0]  r_ptr;
  logic [7:0]        r_cur;
  logic [7:0]        r_pref;
  logic              r_pref_valid;
  logic              r_rd_inflight;
  logic [MEM_AW-1:0] r_rd_addr;

  logic              w_np_edge;
  logic              w_fr_edge;
  logic [MEM_AW-1:0] w_ptr_byte;
  logic [MEM_AW-1:0] w_next_byte;
  logic [PTR_W-1:0]  w_ptr_inc;
  logic              w_rd_need;
  logic [MEM_AW-1:0] w_rd_addr;
  logic [MEM_AW-1:0] w_wr_byte;
  logic              w_wr_ready;
  logic              w_wr_do;
  logic [7:0]        w_cur_snoop;
  logic [7:0]        w_pref_snoop;
  logic              w_advance;

  fb_edge_detect u_np_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (bus.next_pixel_in),
    .rise   (w_np_edge)
  );

  fb_edge_detect u_fr_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (bus.frame_reset_in),
    .rise   (w_fr_edge)
  );

  assign w_ptr_byte  = MEM_AW'(byte_addr(32'(r_ptr)));
  assign w_next_byte = (32'(w_ptr_byte) == NBYTES - 1) ? '0 : w_ptr_byte + MEM_AW'(1);
  assign w_ptr_inc   = (32'(r_ptr) == FB_PIXELS - 1) ? '0 : r_ptr + PTR_W'(1);
  assign w_advance   = w_np_edge && !bus.frame_reset_in && (r_state == STREAM);

  // Reads always win the single RAM port; the prefetch slot is refilled as soon as it empties.
  assign w_rd_need = rst_n && ((r_state == FILL0) || (r_state == FILL1) ||
                     ((r_state == STREAM) && !r_pref_valid && !r_rd_inflight));
  assign w_rd_addr = (r_state == FILL0) ? w_ptr_byte : w_next_byte;

  assign w_wr_byte  = MEM_AW'(byte_addr(32'(bus.wr_addr)));
  // A write to the byte whose read data is about to be captured would be missed by the snoop.
  assign w_wr_ready = rst_n && !w_rd_need && !(r_rd_inflight && (w_wr_byte == r_rd_addr));
  assign w_wr_do    = bus.wr_valid && w_wr_ready && (32'(bus.wr_addr) < FB_PIXELS);

  assign w_cur_snoop  = (w_wr_do && (w_wr_byte == w_ptr_byte)) ?
                        set_nibble(r_cur, bus.wr_addr[0], bus.wr_data) : r_cur;
  assign w_pref_snoop = (w_wr_do && r_pref_valid && (w_wr_byte == w_next_byte)) ?
                        set_nibble(r_pref, bus.wr_addr[0], bus.wr_data) : r_pref;

  assign bus.wr_ready  = w_wr_ready;
  assign bus.mem_re    = w_rd_need;
  assign bus.mem_we    = w_wr_do;
  assign bus.mem_addr  = w_rd_need ? w_rd_addr : (w_wr_do ? w_wr_byte : '0);
  assign bus.mem_wmask = w_wr_do ? (bus.wr_addr[0] ? 2'b10 : 2'b01) : 2'b00;
  assign bus.mem_wdata = {bus.wr_data, bus.wr_data};
  assign bus.pixel_out = r_ptr[0] ? r_cur[7:4] : r_cur[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= FILL0;
      r_ptr         <= '0;
      r_cur         <= '0;
      r_pref        <= '0;
      r_pref_valid  <= 1'b0;
      r_rd_inflight <= 1'b0;
      r_rd_addr     <= '0;
    end else begin
      r_rd_inflight <= w_rd_need;
      r_rd_addr     <= w_rd_addr;
      r_cur         <= w_cur_snoop;
      r_pref        <= w_pref_snoop;
      if (w_fr_edge) begin
        r_state      <= FILL0;
        r_ptr        <= '0;
        r_pref_valid <= 1'b0;
      end else begin
        case (r_state)
          FILL0: r_state <= FILL1;
          FILL1: begin
            r_cur   <= bus.mem_rdata;
            r_state <= FILL2;
          end
          FILL2: begin
            r_pref       <= bus.mem_rdata;
            r_pref_valid <= 1'b1;
            r_state      <= STREAM;
          end
          STREAM: begin
            if (r_rd_inflight) begin
              r_pref       <= bus.mem_rdata;
              r_pref_valid <= 1'b1;
            end
            if (w_advance) begin
              r_ptr <= w_ptr_inc;
              // Leaving the odd pixel crosses into the prefetched byte; an empty slot keeps cur.
              if (r_ptr[0]) begin
                if (r_pref_valid) r_cur <= w_pref_snoop;
                r_pref_valid <= 1'b0;
              end
            end
          end
          default: r_state <= FILL0;
        endcase
      end
    end
  end

`ifdef FB_UNDERFLOW_FLAG_EN
  logic r_underflow;
  logic w_uf_set;

  assign w_uf_set = w_np_edge && !bus.frame_reset_in &&
                    ((r_state != STREAM) || (r_ptr[0] && !r_pref_valid));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_underflow <= 1'b0;
    else if (w_fr_edge) r_underflow <= 1'b0;
    else if (w_uf_set)  r_underflow <= 1'b1;
  end

  assign underflow_out = r_underflow;
`endif

endmodule
`default_nettype wire
